l1_miss_controller: RTL and testbench

- Sequencing controller for the direct-mapped, write-back L1 data cache: 2048 lines × 8 words × 16 bits, 2-bit tag, 16-bit word address.
- Accepts one load/store at a time from the core, does the tag lookup, and drives the single-port data array.
- On a miss it runs dirty-line write-back, then block refill, over a word-serial main-memory handshake.
- Owns the tag/valid/dirty state. The data array is an external 1-cycle-latency SRAM.

---
 rtl/l1_miss_controller_pkg.sv | 11 +
 rtl/l1_miss_controller_if.sv | 16 +
 rtl/l1_tag_store.sv | 26 ++
 rtl/l1_miss_controller.sv | 120 ++++++++++++
 tb/tb_l1_miss_controller.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/l1_miss_controller_pkg.sv
// l1_miss_controller_pkg: cache geometry and controller state encoding
package l1_miss_controller_pkg;
  localparam int TAG_W = 2;
  localparam int INDEX_W = 11;
  localparam int WORD_W = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = TAG_W + INDEX_W + WORD_W;
  localparam int LINE_WORDS = 8;
  localparam int LINES = 1 << INDEX_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_RD, WB_MEM, RF, RESP} state_t;
endpackage

// File: rtl/l1_miss_controller_if.sv
// l1_miss_controller_if: core request/response and word-serial main-memory bus
interface l1_miss_controller_if;
  import l1_miss_controller_pkg::*;
  logic ReqValid, ReqReady, ReqWrite, RespValid, ReadHit, WriteHit;
  logic [ADDR_W-1:0] ReqAddr, MemAddr;
  logic [DATA_W-1:0] ReqWData, RespData, MemWData, MemRData;
  logic MemReq, MemWe, MemAck;
  modport master(
    output ReqValid, ReqWrite, ReqAddr, ReqWData, MemRData, MemAck,
    input ReqReady, RespValid, RespData, ReadHit, WriteHit, MemReq, MemWe, MemAddr, MemWData
  );
  modport slave(
    input ReqValid, ReqWrite, ReqAddr, ReqWData, MemRData, MemAck,
    output ReqReady, RespValid, RespData, ReadHit, WriteHit, MemReq, MemWe, MemAddr, MemWData
  );
endinterface

// File: rtl/l1_tag_store.sv
// l1_tag_store: per-line tag/valid/dirty with combinational lookup and synchronous update
module l1_tag_store import l1_miss_controller_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic [INDEX_W-1:0] idx,
  input  logic upd,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic upd_dirty,
  output logic [TAG_W-1:0] tag,
  output logic valid,
  output logic dirty
);
  logic [TAG_W-1:0] tags [LINES];
  logic [LINES-1:0] valids, dirtys;
  assign tag = tags[idx];
  assign valid = valids[idx];
  assign dirty = dirtys[idx];
  always_ff @(posedge clk) if (upd) tags[idx] <= upd_tag;
  always_ff @(posedge clk) begin
    if (reset) {valids, dirtys} <= '0;
    else if (upd) begin
      valids[idx] <= 1'b1;
      dirtys[idx] <= upd_dirty;
    end
  end
endmodule

// File: rtl/l1_miss_controller.sv
// l1_miss_controller: write-back L1 lookup/miss sequencer; L1_PERF_CNT_EN adds saturating hit/miss/write-back counters
module l1_miss_controller import l1_miss_controller_pkg::*; (
  input  logic clk,
  input  logic reset,
  l1_miss_controller_if.slave bus,
  output logic [INDEX_W+WORD_W-1:0] ArrAddr,
  output logic ArrWe,
  output logic [DATA_W-1:0] ArrWData,
  input  logic [DATA_W-1:0] ArrRData
`ifdef L1_PERF_CNT_EN
  ,
  output logic [15:0] HitCount,
  output logic [15:0] MissCount,
  output logic [15:0] WbCount
`endif
);
  state_t state, nxt;
  logic [WORD_W-1:0] cnt, word;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, wb_q, resp_word;
  logic [TAG_W-1:0] tag, t_tag;
  logic [INDEX_W-1:0] idx;
  logic wr, hit_q, gap, wb_first, hit, ack, last, upd, upd_dirty, t_valid, t_dirty;
  assign {tag, idx, word} = addr;
  assign hit = t_valid && t_tag == tag;
  assign last = cnt == WORD_W'(LINE_WORDS - 1);
  // gap keeps MemReq low the cycle after each refill ack, so an ack there is never a transfer
  assign ack = bus.MemAck && (state == WB_MEM || (state == RF && !gap));
  l1_tag_store tags (
    .clk(clk), .reset(reset), .idx(idx), .upd(upd), .upd_tag(tag), .upd_dirty(upd_dirty),
    .tag(t_tag), .valid(t_valid), .dirty(t_dirty)
  );
  always_comb begin
    nxt = state;
    bus.ReqReady = 1'b0;
    bus.RespValid = 1'b0;
    bus.RespData = '0;
    bus.ReadHit = 1'b0;
    bus.WriteHit = 1'b0;
    bus.MemReq = 1'b0;
    bus.MemWe = 1'b0;
    bus.MemAddr = '0;
    bus.MemWData = '0;
    ArrAddr = '0;
    ArrWe = 1'b0;
    ArrWData = '0;
    upd = 1'b0;
    upd_dirty = 1'b0;
    case (state)
      IDLE: begin
        bus.ReqReady = 1'b1;
        nxt = bus.ReqValid ? LOOKUP : IDLE;
      end
      LOOKUP: begin
        bus.ReadHit = hit && !wr;
        bus.WriteHit = hit && wr;
        ArrAddr = {idx, word};
        ArrWe = hit && wr;
        ArrWData = wdata;
        upd = hit && wr;
        upd_dirty = 1'b1;
        nxt = hit ? RESP : (t_valid && t_dirty) ? WB_RD : RF;
      end
      WB_RD: begin
        ArrAddr = {idx, cnt};
        nxt = WB_MEM;
      end
      WB_MEM: begin
        bus.MemReq = 1'b1;
        bus.MemWe = 1'b1;
        bus.MemAddr = {t_tag, idx, cnt};
        bus.MemWData = wb_first ? ArrRData : wb_q;
        nxt = !ack ? WB_MEM : last ? RF : WB_RD;
      end
      RF: begin
        bus.MemReq = !gap;
        bus.MemAddr = {tag, idx, cnt};
        ArrWe = ack;
        ArrAddr = {idx, cnt};
        ArrWData = (wr && cnt == word) ? wdata : bus.MemRData;
        upd = ack && last;
        upd_dirty = wr;
        nxt = (ack && last) ? RESP : RF;
      end
      RESP: begin
        bus.RespValid = 1'b1;
        bus.RespData = wr ? '0 : hit_q ? ArrRData : resp_word;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      gap <= 1'b0;
      wb_first <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= state == LOOKUP ? '0 : cnt + WORD_W'(ack);
      gap <= ack;
      wb_first <= state == WB_RD;
    end
    if (state == IDLE && bus.ReqValid) {wr, addr, wdata} <= {bus.ReqWrite, bus.ReqAddr, bus.ReqWData};
    if (state == LOOKUP) hit_q <= hit;
    if (wb_first) wb_q <= ArrRData;
    if (state == RF && ack && cnt == word) resp_word <= bus.MemRData;
  end
`ifdef L1_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) {HitCount, MissCount, WbCount} <= '0;
    else begin
      if (state == LOOKUP && hit && !(&HitCount)) HitCount <= HitCount + 16'd1;
      if (state == LOOKUP && !hit && !(&MissCount)) MissCount <= MissCount + 16'd1;
      if (state == WB_MEM && ack && last && !(&WbCount)) WbCount <= WbCount + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_l1_miss_controller.sv
// tb_l1_miss_controller: scoreboard bench against a behavioural write-back cache model
module tb_l1_miss_controller;
  import l1_miss_controller_pkg::*;
  typedef struct { bit w; bit hit; bit [15:0] data; int acc; } resp_t;
  typedef struct { bit we; bit [15:0] addr; bit [15:0] data; } mop_t;
  logic clk = 0, reset = 1;
  logic [13:0] ArrAddr;
  logic ArrWe;
  logic [15:0] ArrWData, ArrRData;
`ifdef L1_PERF_CNT_EN
  logic [15:0] HitCount, MissCount, WbCount;
`endif
  int passed = 0, total = 0, cyc = 0, rf_acks = 0;
  bit force_dly = 0, gap_chk = 0, seen_r = 0, seen_w = 0;
  resp_t rq[$];
  mop_t mq[$];
  resp_t re;
  bit [15:0] rmem [int];
  bit [15:0] mm [int];
  bit mv [LINES];
  bit md [LINES];
  bit [1:0] mt [LINES];
  bit [15:0] mdat [LINES][8];
  bit [15:0] sram [16384];
  l1_miss_controller_if bus();
  l1_miss_controller dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ArrAddr(ArrAddr), .ArrWe(ArrWe), .ArrWData(ArrWData), .ArrRData(ArrRData)
`ifdef L1_PERF_CNT_EN
    , .HitCount(HitCount), .MissCount(MissCount), .WbCount(WbCount)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    ArrRData <= sram[ArrAddr];
    if (ArrWe) sram[ArrAddr] <= ArrWData;
  end
  function automatic bit [15:0] init_val(input bit [15:0] a);
    return 16'h1000 + a;
  endfunction
  function automatic void check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction
  // direct-mapped write-back, write-allocate cache; returns hit and the word the core must see
  function automatic bit model(input bit w, input bit [15:0] a, input bit [15:0] d, output bit [15:0] rd);
    bit [10:0] ix = a[13:3];
    bit [1:0] tg = a[15:14];
    bit [2:0] wd = a[2:0];
    bit [15:0] ma;
    bit h = mv[ix] && mt[ix] == tg;
    if (!h) begin
      if (mv[ix] && md[ix])
        for (int i = 0; i < 8; i++) begin
          ma = {mt[ix], ix, 3'(i)};
          mm[int'(ma)] = mdat[ix][i];
          mq.push_back('{1'b1, ma, mdat[ix][i]});
        end
      for (int i = 0; i < 8; i++) begin
        ma = {tg, ix, 3'(i)};
        mdat[ix][i] = mm.exists(int'(ma)) ? mm[int'(ma)] : init_val(ma);
        mq.push_back('{1'b0, ma, 16'h0});
      end
      mt[ix] = tg;
      mv[ix] = 1;
      md[ix] = 0;
    end
    if (w) begin
      mdat[ix][wd] = d;
      md[ix] = 1;
    end
    rd = w ? 16'h0 : mdat[ix][wd];
    return h;
  endfunction
  task automatic issue(input bit w, input bit [15:0] a, input bit [15:0] d);
    bit [15:0] rd;
    bit h;
    int n = 0;
    @(negedge clk);
    while (!bus.ReqReady && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(bus.ReqReady, "req_ready_wait", int'(bus.ReqReady), 1);
    h = model(w, a, d, rd);
    rq.push_back('{w, h, rd, cyc});
    bus.ReqValid = 1;
    bus.ReqWrite = w;
    bus.ReqAddr = a;
    bus.ReqWData = d;
    @(negedge clk);
    bus.ReqValid = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < LINES; i++) begin
      mv[i] = 0;
      md[i] = 0;
    end
    rq.delete();
    mq.delete();
    @(negedge clk);
    reset = 0;
    check({bus.ReqReady, bus.RespValid, bus.ReadHit, bus.WriteHit, bus.MemReq, ArrWe} == 6'b100000,
          "reset_outputs", int'({bus.ReqReady, bus.RespValid, bus.ReadHit, bus.WriteHit, bus.MemReq, ArrWe}), 6'b100000);
    check(ArrAddr == 0 && bus.MemAddr == 0 && bus.RespData == 0, "reset_addr", int'(ArrAddr), 0);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((rq.size() != 0 || !bus.ReqReady) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(rq.size() == 0 && bus.ReqReady, "idle_wait", rq.size(), 0);
  endtask
  always @(negedge clk) begin
    if (bus.ReadHit) seen_r = 1;
    if (bus.WriteHit) seen_w = 1;
    if (bus.RespValid) begin
      if (rq.size() == 0) check(0, "resp_unexpected", int'(bus.RespData), 0);
      else begin
        re = rq.pop_front();
        check(bus.RespData == re.data, "resp_data", int'(bus.RespData), int'(re.data));
        check({seen_r, seen_w} == {re.hit && !re.w, re.hit && re.w}, "hit_flags",
              int'({seen_r, seen_w}), int'({re.hit && !re.w, re.hit && re.w}));
        if (re.hit) check(cyc - re.acc == 2, "hit_latency", cyc - re.acc, 2);
      end
      seen_r = 0;
      seen_w = 0;
    end
  end
  initial begin
    bit we, ok;
    bit [15:0] a, wd;
    int dly;
    mop_t e;
    bus.MemAck = 0;
    bus.MemRData = 0;
    forever begin
      @(negedge clk);
      bus.MemAck = 0;
      if (gap_chk) begin
        check(!bus.MemReq, "mem_gap", int'(bus.MemReq), 0);
        gap_chk = 0;
      end
      if (bus.MemReq && !reset) begin
        we = bus.MemWe;
        a = bus.MemAddr;
        wd = bus.MemWData;
        dly = force_dly ? 5 : $urandom_range(0, 2);
        ok = 1;
        for (int k = 0; k < dly && ok; k++) begin
          @(negedge clk);
          if (!bus.MemReq) begin
            ok = 0;
            if (!reset) check(0, "mem_dropped", int'(a), 0);
          end else
            check(bus.MemWe == we && bus.MemAddr == a && (!we || bus.MemWData == wd), "mem_stable",
                  int'({bus.MemWe, bus.MemAddr}), int'({we, a}));
        end
        if (ok && !reset) begin
          if (mq.size() == 0) check(0, "mem_unexpected", int'({we, a}), 0);
          else begin
            e = mq.pop_front();
            check(we == e.we && a == e.addr, "mem_op", int'({we, a}), int'({e.we, e.addr}));
            if (e.we) check(wd == e.data, "wb_data", int'(wd), int'(e.data));
          end
          if (we) rmem[int'(a)] = wd;
          else begin
            bus.MemRData = rmem.exists(int'(a)) ? rmem[int'(a)] : init_val(a);
            rf_acks++;
          end
          bus.MemAck = 1;
          gap_chk = 1;
        end
      end
    end
  end
  initial begin
    bit [1:0] tg;
    bit [10:0] ix;
    int n = 0;
    bus.ReqValid = 0;
    bus.ReqWrite = 0;
    bus.ReqAddr = 0;
    bus.ReqWData = 0;
    do_reset();
    issue(0, 16'h0005, 16'h0);
    issue(1, 16'h0005, 16'hBEEF);
    issue(0, 16'h0005, 16'h0);
    issue(0, 16'h4005, 16'h0);
    issue(0, 16'h0005, 16'h0);
    issue(1, 16'h8003, 16'h1234);
    issue(0, 16'h8003, 16'h0);
    wait_idle();
    force_dly = 1;
    issue(0, 16'h4003, 16'h0);
    wait_idle();
    force_dly = 0;
    rf_acks = 0;
    issue(0, 16'hC00F, 16'h0);
    while (rf_acks < 3 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check(rf_acks >= 3, "refill_ack_wait", rf_acks, 3);
    do_reset();
    issue(0, 16'hC00F, 16'h0);
    for (int i = 0; i < 150; i++) begin
      tg = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ix = 11'd0;
        1: ix = 11'd1;
        2: ix = 11'd2;
        default: ix = 11'h7FF;
      endcase
      issue(1'($urandom_range(0, 1)), {tg, ix, 3'($urandom_range(0, 7))}, 16'($urandom));
    end
    wait_idle();
    check(mq.size() == 0, "mem_leftover", mq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
